// File: rtl/alu_share_if.sv
// alu_share_if: requester, ALU, response and flag signals of the shared ALU controller
interface alu_share_if #(parameter int WIDTH = 16, parameter int OPW = 4);
  logic req0_valid, req0_ready;
  logic [OPW-1:0] req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic req1_valid, req1_ready;
  logic [OPW-1:0] req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [OPW-1:0] alu_op;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_out;
  logic alu_err;
  logic rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic flag_n, flag_z, flag_v;
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input alu_out, alu_err, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_in1, alu_in2,
    output rsp_valid, rsp_src, rsp_data, rsp_err, flag_n, flag_z, flag_v
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output alu_out, alu_err, rsp_ready,
    input req0_ready, req1_ready, alu_op, alu_in1, alu_in2,
    input rsp_valid, rsp_src, rsp_data, rsp_err, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two requesters with N/Z/V flags
module alu_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int OPW = 4
) (
  input logic clk,
  input logic rst,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, src_r, gnt1, take, ill, upd_nv, upd_z;
  logic [OPW-1:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, data_r;
  logic src_o, err_r, n_r, z_r, v_r;
  // arbitration, next state and ALU/response drive
  always_comb begin
    gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    take = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    ill = op_r[OPW-1];
    upd_nv = !ill && op_r[2:1] == 2'b00;
    upd_z = !ill && op_r[1:0] != 2'b11;
    state_nx = take ? EXEC : state == EXEC ? RESP : (state == RESP && bus.rsp_ready) ? IDLE : state;
    bus.req0_ready = (state == IDLE) && bus.req0_valid && !gnt1;
    bus.req1_ready = (state == IDLE) && gnt1;
    bus.alu_op = state == EXEC ? op_r : '0;
    bus.alu_in1 = state == EXEC ? a_r : '0;
    bus.alu_in2 = state == EXEC ? b_r : '0;
    bus.rsp_valid = state == RESP;
    bus.rsp_src = src_o;
    bus.rsp_data = data_r;
    bus.rsp_err = err_r;
    bus.flag_n = n_r;
    bus.flag_z = z_r;
    bus.flag_v = v_r;
  end
  // state, operand latch on grant, result and flag capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      src_r <= 1'b0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      data_r <= '0;
      src_o <= 1'b0;
      err_r <= 1'b0;
      n_r <= 1'b0;
      z_r <= 1'b0;
      v_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_r <= gnt1 ? bus.req1_op : bus.req0_op;
        a_r <= gnt1 ? bus.req1_a : bus.req0_a;
        b_r <= gnt1 ? bus.req1_b : bus.req0_b;
        src_r <= gnt1;
        last_grant <= gnt1;
      end
      if (state == EXEC) begin
        data_r <= ill ? '0 : bus.alu_out;
        src_o <= src_r;
        err_r <= ill;
        if (upd_nv) begin
          n_r <= bus.alu_out[WIDTH-1];
          v_r <= bus.alu_err;
        end
        if (upd_z) z_r <= bus.alu_out == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, latency, backpressure, flags and reset
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  alu_share_if #(.WIDTH(16), .OPW(4)) bus();
  alu_share_ctrl #(.WIDTH(16), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_res(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << 1;
      4'h7: return a >> 1;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    s = alu_res(op, a, b);
    if (op == 4'h0) return (a[15] == b[15]) && (s[15] != a[15]);
    if (op == 4'h1) return (a[15] != b[15]) && (s[15] != a[15]);
    return 1'b0;
  endfunction

  assign bus.alu_out = alu_res(bus.alu_op, bus.alu_in1, bus.alu_in2);
  assign bus.alu_err = alu_ovf(bus.alu_op, bus.alu_in1, bus.alu_in2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (r) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic run(input string tag, input bit r, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] ed, input logic ee, input logic [2:0] nzv);
    drive(r, 1'b1, op, a, b);
    #1;
    chk({tag, "_ready"}, r ? bus.req1_ready : bus.req0_ready, 1);
    chk({tag, "_other_ready"}, r ? bus.req0_ready : bus.req1_ready, 0);
    tick();
    drive(r, 1'b0, 4'h0, 16'h0, 16'h0);
    #1;
    chk({tag, "_exec_op"}, bus.alu_op, op);
    chk({tag, "_exec_in1"}, bus.alu_in1, a);
    chk({tag, "_exec_in2"}, bus.alu_in2, b);
    chk({tag, "_exec_valid"}, bus.rsp_valid, 0);
    tick();
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, "_rsp_data"}, bus.rsp_data, ed);
    chk({tag, "_rsp_src"}, bus.rsp_src, r);
    chk({tag, "_rsp_err"}, bus.rsp_err, ee);
    chk({tag, "_flags"}, {bus.flag_n, bus.flag_z, bus.flag_v}, nzv);
    tick();
    chk({tag, "_idle_valid"}, bus.rsp_valid, 0);
  endtask

  initial begin
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'h0, 16'h0, 16'h0);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);
    chk("reset_alu_op", bus.alu_op, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_ready0", bus.req0_ready, 0);
    run("add", 0, 4'h0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 3'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 4'h0, 16'h0001, 16'h0001);
    drive(1, 1'b1, 4'h2, 16'hF0F0, 16'h0FF0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_exec_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      tick();
      chk("rr_src", bus.rsp_src, i % 2);
      chk("rr_data", bus.rsp_data, (i % 2 == 1) ? 16'h00F0 : 16'h0002);
      chk("rr_resp_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      tick();
    end
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'h0, 16'h0, 16'h0);
    run("sub_ovf", 1, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 3'b001);
    run("sub_zero", 1, 4'h1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'b010);
    bus.rsp_ready = 1'b0;
    drive(0, 1'b1, 4'h0, 16'h0005, 16'h0006);
    #1;
    chk("bp_accept", bus.req0_ready, 1);
    tick();
    drive(0, 1'b1, 4'h3, 16'h0001, 16'h0002);
    #1;
    chk("bp_exec_ready0", bus.req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_data", bus.rsp_data, 16'h000B);
      chk("bp_hold_ready0", bus.req0_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_handshake_ready0", bus.req0_ready, 0);
    chk("bp_handshake_valid", bus.rsp_valid, 1);
    tick();
    chk("bp_next_accept", bus.req0_ready, 1);
    tick();
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    tick();
    chk("bp_or_data", bus.rsp_data, 16'h0003);
    chk("bp_or_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);
    tick();
    run("set_z", 0, 4'h1, 16'h0042, 16'h0042, 16'h0000, 1'b0, 3'b010);
    run("illegal", 1, 4'hA, 16'h0007, 16'h0009, 16'h0000, 1'b1, 3'b010);
    run("or_keep", 0, 4'h3, 16'h0001, 16'h0002, 16'h0003, 1'b0, 3'b010);
    drive(0, 1'b1, 4'h0, 16'h0001, 16'h0001);
    tick();
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exec_valid", bus.rsp_valid, 0);
    chk("rst_exec_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 3'b000);
    drive(0, 1'b1, 4'h0, 16'h0002, 16'h0003);
    drive(1, 1'b1, 4'h4, 16'h00FF, 16'h0F0F);
    #1;
    chk("rst_first_ready0", bus.req0_ready, 1);
    chk("rst_first_ready1", bus.req1_ready, 0);
    tick();
    tick();
    chk("rst_first_src", bus.rsp_src, 0);
    chk("rst_first_data", bus.rsp_data, 16'h0005);
    tick();
    chk("rst_second_ready1", bus.req1_ready, 1);
    drive(0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1, 1'b0, 4'h0, 16'h0, 16'h0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences the single shared 16-bit ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-target unit.
- Arbitrates requests round-robin, latches operands, and drives the ALU opcode and operand inputs.
- Captures the ALU result and overflow indication, and returns the result with a valid/ready handshake.
- Owns the architectural N/Z/V flag register. Only one operation is in flight at a time.

Parameters:
WIDTH, 16, datapath width of operands and result
OPW, 4, opcode width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  OPW  requester 0 opcode
req0_a  input  WIDTH  requester 0 operand 1
req0_b  input  WIDTH  requester 0 operand 2
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
alu_op  output  OPW  opcode to ALU
alu_in1  output  WIDTH  operand 1 to ALU
alu_in2  output  WIDTH  operand 2 to ALU
alu_out  input  WIDTH  ALU result; combinational from alu_op/alu_in1/alu_in2
alu_err  input  1  ALU overflow indication
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_src  output  1  requester index of the result
rsp_data  output  WIDTH  result
rsp_err  output  1  illegal opcode (op[3]=1)
flag_n  output  1  negative flag
flag_z  output  1  zero flag
flag_v  output  1  overflow flag

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0; flags 0; internal op/operand registers 0; last_grant=1, so requester 0 wins the first contention.
- IDLE:
  - One valid requester: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - The granted reqN_ready is asserted combinationally for that cycle only; the other ready stays 0.
  - On grant, latch op, a, b and src; set last_grant=src; go to EXEC.
  - No valid requester: stay in IDLE; both readies 0.
- EXEC (exactly 1 cycle):
  - alu_op/alu_in1/alu_in2 driven from the latched registers.
  - At end of cycle, register rsp_data=alu_out, rsp_src=src, rsp_err=op[3]; go to RESP.
  - If op[3]=1, rsp_data=0 instead, and flags are untouched.
- ALU drive in IDLE and RESP: alu_op/alu_in1/alu_in2 are 0.
- Flag update (at the EXEC capture edge):
  - op 0000/0001: N=alu_out[15], Z=(alu_out==0), V=alu_err.
  - op 0010, 0100, 0101, 0110: Z only.
  - op 0011, 0111: no flag change.
- RESP:
  - rsp_valid=1; rsp_data/rsp_src/rsp_err held stable until rsp_valid&rsp_ready, then go to IDLE.
  - No request is accepted in RESP, including the handshake cycle.
- Latency:
  - Accept at cycle T gives rsp_valid at T+2.
  - Minimum spacing between accepts is 3 cycles.
- Requester rules: a requester holds valid and its fields until ready. Deasserting valid before ready is permitted and simply withdraws the request.
- Reset mid-operation: rst in EXEC or RESP returns to IDLE next edge. The in-flight result is dropped, rsp_valid=0, flags cleared, last_grant=1.
- rst has priority over all other events in the same cycle.

Test Plan:
- ADD from req0 only:
  - Stimulus: req0 op=0000, a=0x0003, b=0x0004, accepted at T.
  - Response: rsp_valid at T+2, rsp_data=0x0007, rsp_src=0, N=0 Z=0 V=0.
- Simultaneous contention after reset:
  - Stimulus: req0 and req1 both valid continuously.
  - Response: grants go 0,1,0,1, accepts 3 cycles apart with rsp_ready tied high; the non-granted ready stays 0.
- SUB overflow and zero:
  - Stimulus: req1 op=0001, a=0x8000, b=0x0001, with alu_err=1 from the ALU.
  - Response: V=1; rsp_src=1.
  - Follow-up: op=0001, a=b=0x1234 gives rsp_data=0x0000, Z=1, V=0.
- Backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles in RESP while req0_valid=1.
  - Response: rsp_data is stable and req0_ready=0 throughout; req0 is accepted the cycle after the handshake.
- Illegal op and flag preservation:
  - Stimulus: op=1010 issued after flags Z=1, N=0, V=0.
  - Response: rsp_err=1, rsp_data=0x0000; flags still Z=1, N=0, V=0.
  - Follow-up: op=0011 leaves flags unchanged.
- Reset mid-EXEC:
  - Stimulus: rst asserted in the EXEC cycle.
  - Response: next cycle state is IDLE, rsp_valid=0, flags=0; simultaneous requests then grant req0 first.
